// File: rtl/digital_out_arbiter.sv
// digital_out_arbiter
//
// Collects signed result words from NCH synchronous sources into one holding
// register per channel. One channel per cycle is granted in fixed-channel or
// round-robin order, and its word goes into a DEPTH-entry first-word-fall-through
// FIFO. The FIFO presents a ready/valid output toward the pad serializer.
// A word that arrives while its channel's holding register is still occupied
// is dropped. Every such word is counted in a saturating 8-bit counter.
//
// Optional build macro:
//   DIGITAL_OUT_TAG_EN - FIFO entries carry the source channel index next to
//                        the data word, and the OUT_TAG port is present.
//                        Without it, entries hold data only and OUT_TAG is
//                        absent.
module digital_out_arbiter #(
    parameter  int NCH   = 4,
    parameter  int BW    = 21,
    parameter  int DEPTH = 8,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      CLK,
    input  logic                      RES,
    input  logic [NCH-1:0]            ENABLE,
    input  logic                      MODE,
    input  logic [CW-1:0]             SEL,
    input  logic [NCH-1:0]            IN_VALID,
    input  logic [NCH*BW-1:0]         IN_DATA,
    input  logic                      OUT_READY,
    output logic                      OUT_VALID,
    output logic signed [BW-1:0]      OUT,
`ifdef DIGITAL_OUT_TAG_EN
    output logic [CW-1:0]             OUT_TAG,
`endif
    output logic [$clog2(DEPTH):0]    FIFO_LEVEL,
    output logic [7:0]                OVF_CNT
);

    // FIFO addressing: DEPTH is a power of two, so the pointers wrap on their own
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
`ifdef DIGITAL_OUT_TAG_EN
    localparam int EW = BW + CW;
`else
    localparam int EW = BW;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NCH-1:0]  r_hold_v;
    logic [BW-1:0]   r_hold_d [NCH];
    logic [CW-1:0]   r_ptr;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_ovf;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic            w_out_valid;
    logic            w_pop;
    logic            w_full;
    logic            w_can_push;
    logic [NCH-1:0]  w_req;
    logic            w_grant_vld;
    logic [CW-1:0]   w_grant_idx;
    logic [NCH-1:0]  w_grant_oh;
    logic [NCH-1:0]  w_strobe;
    logic [NCH-1:0]  w_load;
    logic [NCH-1:0]  w_drop;
    logic [8:0]      w_drop_cnt;
    logic [8:0]      w_ovf_sum;
    logic [7:0]      w_ovf_next;
    logic [EW-1:0]   w_push_entry;

    // FIFO handshake: a pop frees a slot for a push in the same cycle
    assign w_out_valid = (r_level != '0);
    assign w_pop       = w_out_valid & OUT_READY;
    assign w_full      = (r_level == LW'(DEPTH));
    assign w_can_push  = !w_full | w_pop;

    // A channel whose enable is low is not offered to the arbiter. Its held
    // word is discarded at the next edge instead.
    assign w_req = r_hold_v & ENABLE;

    // Pick at most one channel: SEL in fixed mode, or the next requester after r_ptr
    // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
    always_comb begin
        logic [CW-1:0] v_idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        v_idx       = '0;
        if (w_can_push) begin
            if (!MODE) begin
                if ((int'(SEL) < NCH) && w_req[SEL]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = SEL;
                end
            end else begin
                for (int i = 1; i <= NCH; i++) begin
                    v_idx = CW'((int'(r_ptr) + i) % NCH);
                    if (!w_grant_vld && w_req[v_idx]) begin
                        w_grant_vld = 1'b1;
                        w_grant_idx = v_idx;
                    end
                end
            end
        end
    end

    assign w_grant_oh = w_grant_vld ? (NCH'(1) << w_grant_idx) : '0;

    // Capture: a strobe loads when the register is free or is being emptied by this grant
    assign w_strobe = IN_VALID & ENABLE;
    assign w_load   = w_strobe & (~r_hold_v | w_grant_oh);
    assign w_drop   = w_strobe & ~w_load;

    // Count the words dropped this cycle and saturate the running total at 255
    always_comb begin
        w_drop_cnt = '0;
        for (int k = 0; k < NCH; k++) begin
            w_drop_cnt = w_drop_cnt + 9'(w_drop[k]);
        end
        w_ovf_sum  = {1'b0, r_ovf} + w_drop_cnt;
        w_ovf_next = (w_ovf_sum > 9'd255) ? 8'hFF : w_ovf_sum[7:0];
    end

    // Word pushed into the FIFO tail for the granted channel
`ifdef DIGITAL_OUT_TAG_EN
    assign w_push_entry = {w_grant_idx, r_hold_d[w_grant_idx]};
`else
    assign w_push_entry = r_hold_d[w_grant_idx];
`endif

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Per-channel holding registers: enable-low clear, then reload, then grant clear
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_hold_v <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_hold_d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (!ENABLE[k]) begin
                    r_hold_v[k] <= 1'b0;
                end else if (w_load[k]) begin
                    r_hold_v[k] <= 1'b1;
                    r_hold_d[k] <= IN_DATA[k*BW +: BW];
                end else if (w_grant_oh[k]) begin
                    r_hold_v[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer: follows round-robin grants only and is kept while in fixed mode
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_ptr <= CW'(NCH - 1);
        end else if (w_grant_vld && MODE) begin
            r_ptr <= w_grant_idx;
        end
    end

    // FIFO storage. The head entry drives OUT directly, so the head must read as 0 after reset.
    // NOTE: the storage array is reset on purpose. It is small, and its head entry is visible on OUT.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_mem[d] <= '0;
            end
        end else if (w_grant_vld) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers and occupancy. Push together with pop leaves the level unchanged.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_grant_vld) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_grant_vld, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Dropped-word counter. It saturates at 255 and clears only on reset.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= w_ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all are taken from registers only
    // ------------------------------------------------------------------
    assign OUT_VALID  = w_out_valid;
    assign OUT        = r_mem[r_rd_ptr][BW-1:0];
`ifdef DIGITAL_OUT_TAG_EN
    assign OUT_TAG    = r_mem[r_rd_ptr][EW-1:BW];
`endif
    assign FIFO_LEVEL = r_level;
    assign OVF_CNT    = r_ovf;

endmodule

// File: tb/tb_digital_out_arbiter.sv
// tb_digital_out_arbiter
// Directed scenarios followed by a randomized phase. After every clock edge
// the DUT outputs are compared against a behavioural model that keeps the
// FIFO as a queue and the holding registers as plain arrays.
// Build with DIGITAL_OUT_TAG_EN defined to also check OUT_TAG.
module tb_digital_out_arbiter;

    localparam int NCH   = 4;
    localparam int BW    = 21;
    localparam int DEPTH = 8;
    localparam int CW    = 2;

    logic              CLK = 1'b0;
    logic              RES;
    logic [NCH-1:0]    ENABLE;
    logic              MODE;
    logic [CW-1:0]     SEL;
    logic [NCH-1:0]    IN_VALID;
    logic [NCH*BW-1:0] IN_DATA;
    logic              OUT_READY;
    wire               OUT_VALID;
    wire [BW-1:0]      OUT;
`ifdef DIGITAL_OUT_TAG_EN
    wire [CW-1:0]      OUT_TAG;
`endif
    wire [3:0]         FIFO_LEVEL;
    wire [7:0]         OVF_CNT;

    digital_out_arbiter #(.NCH(NCH), .BW(BW), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RES        (RES),
        .ENABLE     (ENABLE),
        .MODE       (MODE),
        .SEL        (SEL),
        .IN_VALID   (IN_VALID),
        .IN_DATA    (IN_DATA),
        .OUT_READY  (OUT_READY),
        .OUT_VALID  (OUT_VALID),
        .OUT        (OUT),
`ifdef DIGITAL_OUT_TAG_EN
        .OUT_TAG    (OUT_TAG),
`endif
        .FIFO_LEVEL (FIFO_LEVEL),
        .OVF_CNT    (OVF_CNT)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [BW-1:0] data;
        int            tag;
    } entry_t;

    entry_t        m_fifo[$];
    bit            m_hold_v[NCH];
    logic [BW-1:0] m_hold_d[NCH];
    int            m_ptr;
    int            m_ovf;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_fifo.delete();
        for (int k = 0; k < NCH; k++) begin
            m_hold_v[k] = 1'b0;
            m_hold_d[k] = '0;
        end
        m_ptr = NCH - 1;
        m_ovf = 0;
    endtask

    // One clock edge of the model, using the inputs currently applied
    task automatic m_step();
        bit     pop;
        bit     can;
        int     g;
        int     c;
        entry_t e;
        pop = (m_fifo.size() > 0) && OUT_READY;
        can = (m_fifo.size() < DEPTH) || pop;
        g   = -1;
        if (can) begin
            if (!MODE) begin
                if (m_hold_v[SEL] && ENABLE[SEL]) g = int'(SEL);
            end else begin
                for (int i = 1; i <= NCH; i++) begin
                    c = (m_ptr + i) % NCH;
                    if (g < 0 && m_hold_v[c] && ENABLE[c]) g = c;
                end
            end
        end
        if (pop) m_fifo.delete(0);
        if (g >= 0) begin
            e.data = m_hold_d[g];
            e.tag  = g;
            m_fifo.push_back(e);
            if (MODE) m_ptr = g;
        end
        for (int k = 0; k < NCH; k++) begin
            if (!ENABLE[k]) begin
                m_hold_v[k] = 1'b0;
            end else if (IN_VALID[k]) begin
                if (!m_hold_v[k] || g == k) begin
                    m_hold_v[k] = 1'b1;
                    m_hold_d[k] = IN_DATA[k*BW +: BW];
                end else begin
                    m_ovf++;
                end
            end else if (g == k) begin
                m_hold_v[k] = 1'b0;
            end
        end
        if (m_ovf > 255) m_ovf = 255;
    endtask

    task automatic compare(input string tag);
        check({tag, "/valid"}, OUT_VALID, (m_fifo.size() > 0));
        check({tag, "/level"}, FIFO_LEVEL, m_fifo.size());
        check({tag, "/ovf"}, OVF_CNT, m_ovf);
        if (m_fifo.size() > 0) begin
            check({tag, "/out"}, OUT, m_fifo[0].data);
`ifdef DIGITAL_OUT_TAG_EN
            check({tag, "/tag"}, OUT_TAG, m_fifo[0].tag);
`endif
        end
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        m_step();
        #1;
        compare(tag);
    endtask

    task automatic drive(input int k, input int val);
        IN_VALID[k] = 1'b1;
        IN_DATA[k*BW +: BW] = BW'(val);
    endtask

    task automatic idle();
        IN_VALID = '0;
    endtask

    task automatic do_reset();
        RES = 1'b1;
        #2;
        RES = 1'b0;
        m_reset();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        RES       = 1'b1;
        ENABLE    = '0;
        MODE      = 1'b0;
        SEL       = '0;
        IN_VALID  = '0;
        IN_DATA   = '0;
        OUT_READY = 1'b0;
        m_reset();
        #12;
        check("reset/valid", OUT_VALID, 0);
        check("reset/out", OUT, 0);
        check("reset/level", FIFO_LEVEL, 0);
        check("reset/ovf", OVF_CNT, 0);
`ifdef DIGITAL_OUT_TAG_EN
        check("reset/tag", OUT_TAG, 0);
`endif
        RES = 1'b0;

        // Single word on ch2: one cycle of latency after the sampling edge
        MODE = 1'b1; ENABLE = 4'b1111; OUT_READY = 1'b1;
        drive(2, -5);
        step("single/sample");
        check("single/lat0", OUT_VALID, 0);
        idle();
        step("single/push");
        check("single/lat1", OUT_VALID, 1);
        check("single/data", OUT, 21'h1FFFFB);
`ifdef DIGITAL_OUT_TAG_EN
        check("single/tag", OUT_TAG, 2);
`endif
        step("single/pop");
        check("single/empty", FIFO_LEVEL, 0);

        // Round-robin: all four channels strobe together
        do_reset();
        MODE = 1'b1; ENABLE = 4'b1111; OUT_READY = 1'b1;
        for (int k = 0; k < NCH; k++) drive(k, 10 * (k + 1));
        step("rr/sample");
        idle();
        for (int k = 0; k < NCH; k++) begin
            step("rr/drain");
            check("rr/order", OUT, 10 * (k + 1));
        end
        step("rr/done");
        check("rr/empty", OUT_VALID, 0);

        // Fixed mode: ch3 overflows while ch1 drains
        do_reset();
        MODE = 1'b0; SEL = 2'd1; ENABLE = 4'b1111; OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 100 + i);
            drive(3, 300 + i);
            step("fixed/run");
        end
        idle();
        check("fixed/ovf9", OVF_CNT, 9);
        for (int i = 0; i < 3; i++) step("fixed/tail");

        // Backpressure to full, then push and pop together at full
        do_reset();
        MODE = 1'b1; ENABLE = 4'b1111; OUT_READY = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 1000 + i);
            step("bp/fill");
        end
        idle();
        check("bp/full", FIFO_LEVEL, 8);
        check("bp/ovf3", OVF_CNT, 3);
        check("bp/head", OUT, 1000);
        OUT_READY = 1'b1;
        step("bp/pushpop");
        check("bp/stay8", FIFO_LEVEL, 8);
        check("bp/next", OUT, 1001);
        for (int i = 0; i < 9; i++) step("bp/drain");
        check("bp/drained", FIFO_LEVEL, 0);

        // Deasserting ENABLE discards a held word
        do_reset();
        MODE = 1'b0; SEL = 2'd1; ENABLE = 4'b1111; OUT_READY = 1'b1;
        drive(0, 77);
        step("en/sample");
        idle();
        ENABLE = 4'b1110;
        step("en/clear");
        ENABLE = 4'b1111; MODE = 1'b1;
        for (int i = 0; i < 3; i++) step("en/after");
        check("en/nothing", OUT_VALID, 0);

        // Asynchronous reset between edges with 5 words buffered
        do_reset();
        MODE = 1'b0; SEL = 2'd0; ENABLE = 4'b1111; OUT_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 500 + i);
            drive(1, 600 + i);
            step("ares/fill");
        end
        idle();
        check("ares/level5", FIFO_LEVEL, 5);
        check("ares/ovf5", OVF_CNT, 5);
        #2;
        RES = 1'b1;
        #1;
        check("ares/valid", OUT_VALID, 0);
        check("ares/level", FIFO_LEVEL, 0);
        check("ares/ovf", OVF_CNT, 0);
        m_reset();
        #1;
        RES = 1'b0;
        step("ares/after");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ENABLE    = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : 4'b1111;
            if ($urandom_range(0, 19) == 0) MODE = ~MODE;
            if ($urandom_range(0, 9) == 0) SEL = CW'($urandom);
            OUT_READY = ($urandom_range(0, 9) < 7);
            idle();
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 3) == 0) drive(k, int'($urandom));
            end
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digital_out_arbiter.md
# digital_out_arbiter

Parametrised successor to the fixed two-source output selector of the test-chip digital top. Collects signed result words from `NCH` synchronous sources (DFE lanes, ADC TEG paths), arbitrates them in fixed or round-robin mode and buffers them in a `DEPTH`-entry first-word-fall-through FIFO with a ready/valid output toward the pad serializer. All sources are already synchronised into `CLK`. Dropped words are counted rather than silently lost.

## Interface

- `NCH`, 4, number of source channels (≥2).
- `BW`, 21, signed word width per channel.
- `DEPTH`, 8, FIFO depth (power of two, ≥2).
- `CW`, derived `$clog2(NCH)`, channel index width; not overridden.
- `CLK` in 1: single clock, rising edge.
- `RES` in 1: reset, asynchronous, active-high.
- `ENABLE` in NCH: per-channel enable.
- `MODE` in 1: 0 = fixed channel `SEL`, 1 = round-robin.
- `SEL` in CW: channel drained in fixed mode.
- `IN_VALID` in NCH: per-channel word strobe, one cycle per word.
- `IN_DATA` in NCH*BW: channel k at `[k*BW +: BW]`, signed.
- `OUT_READY` in 1: downstream accepts the head word.
- `OUT_VALID` out 1: FIFO non-empty.
- `OUT` out BW: FIFO head word, signed.
- `OUT_TAG` out CW: channel index of the head word (macro only).
- `FIFO_LEVEL` out `$clog2(DEPTH)+1`: occupancy, 0..DEPTH.
- `OVF_CNT` out 8: dropped-word count, saturating.

## Operation

- **Capture.** Each channel has one holding register (`hold_v[k]`, `hold_d[k]`).
  - `IN_VALID[k] & ENABLE[k]` loads it if it is empty or granted this cycle.
  - Otherwise the new word is dropped, the old word is kept and `OVF_CNT` increments.
- **Enable.** `ENABLE[k]` low clears `hold_v[k]` at the next edge and ignores `IN_VALID[k]`.
- **Arbitration.** At most one grant per cycle, only while the FIFO can accept: `FIFO_LEVEL < DEPTH`, or a pop occurs in the same cycle.
  - `MODE=0`: grant `SEL` only, when `hold_v[SEL]`. Other channels keep capturing and overflow.
  - `MODE=1`: grant the first channel with `hold_v` set, searching `ptr+1, ptr+2, …` modulo NCH. `ptr` updates to the granted index.
  - `ptr` resets to NCH-1, so channel 0 wins first. It is retained across `MODE` changes.
- **Grant.** The word is pushed to the FIFO tail and `hold_v` clears, unless reloaded in the same cycle.
- **FIFO.**
  - Pop = `OUT_VALID & OUT_READY`.
  - Simultaneous push and pop leaves the level unchanged, including at full and at empty+1.
  - `OUT`/`OUT_TAG` hold the head word and stay stable while `OUT_VALID & !OUT_READY`.
- **Overflow counter.** `OVF_CNT` adds at most NCH per cycle (several channels may drop together) and saturates at 255. It clears only on `RES`.
- **Reset.** All outputs and internal state are 0 (`OUT_VALID=0`, `OUT=0`, `OUT_TAG=0`, `FIFO_LEVEL=0`, `OVF_CNT=0`); `ptr` = NCH-1. `RES` mid-operation discards held and buffered words immediately.

## Timing

- Input is sampled at edge t, so `hold_v` is set after t.
- With an empty FIFO and a grant, the word is pushed at t+1. `OUT_VALID=1` with that word after t+1, giving 1-cycle latency from the sampling edge.
- Popped at edge p: the next head word (or `OUT_VALID=0`) appears after p.
- Sustained throughput is one word per cycle in total across all channels. A channel strobing every cycle alone in round-robin never drops: it is reloaded on the grant cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration

- `DIGITAL_OUT_TAG_EN` defined:
  - FIFO entries are BW+CW bits wide.
  - Port `OUT_TAG` exists and carries the source channel of the head word.
- Not defined:
  - `OUT_TAG` port is absent.
  - FIFO entries are BW bits wide.
  - Behaviour is otherwise identical.

## Test plan

- **Reset / single word:** reset, then `MODE=1`, `ENABLE=4'b1111`, a single `IN_VALID[2]` with data -5, `OUT_READY=1`. Expect `OUT=-5`, `OUT_TAG=2`, `OUT_VALID` high exactly one cycle after the sampling edge, `FIFO_LEVEL` returning to 0.
- **Round-robin order:** all four channels strobe once on the same edge, data 10/20/30/40. Expect output order ch0, ch1, ch2, ch3 on consecutive cycles, then `OUT_VALID=0`.
- **Fixed mode overflow:** `MODE=0`, `SEL=1`, ch1 and ch3 strobe every cycle for 10 cycles. Expect only ch1 words at `OUT`. Expect `OVF_CNT=9`: the first ch3 word is held, the remaining 9 are dropped.
- **Backpressure / full:** `OUT_READY=0`, 12 words from ch0 at one per cycle, `DEPTH=8`. Expect `FIFO_LEVEL=8` and the 9th word held. Expect `OVF_CNT=3`, then `OUT_READY=1` drains the first 9 words in order.
- **Simultaneous push/pop at full:** FIFO full, `OUT_READY=1`, and ch0 holding a word. Expect push accepted in the same cycle and `FIFO_LEVEL` staying at 8.
- **Enable drop / async reset:**
  - Deassert `ENABLE[0]` while `hold_v[0]` is set: the word is discarded, not output.
  - Assert `RES` between edges with 5 words buffered: `OUT_VALID`, `FIFO_LEVEL` and `OVF_CNT` go to 0 immediately.
